// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the next-PC source sequencer.
// Optional branch statistics are built in with PCSEQ_BRANCH_STATS_EN.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IC_SEQ = 3'd0,
    IC_BEQ = 3'd1,
    IC_BNE = 3'd2,
    IC_BLE = 3'd3,
    IC_BGT = 3'd4,
    IC_J   = 3'd5,
    IC_JR  = 3'd6,
    IC_JAL = 3'd7
  } instr_class_e;

  localparam logic [2:0] PCS_SEQ    = 3'b000;
  localparam logic [2:0] PCS_BRANCH = 3'b001;
  localparam logic [2:0] PCS_JUMP   = 3'b010;
  localparam logic [2:0] PCS_REGA   = 3'b011;
  localparam logic [2:0] PCS_EXCVEC = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_WAIT_FLAGS,
    S_COMMIT,
    S_EXC_EPC,
    S_EXC_READ,
    S_EXC_LOAD
  } state_e;

  localparam logic [1:0] CAUSE_OVF  = 2'd0;
  localparam logic [1:0] CAUSE_OPC  = 2'd1;
  localparam logic [1:0] CAUSE_DIV0 = 2'd2;

  function automatic logic is_branch(input instr_class_e c);
    return c inside {IC_BEQ, IC_BNE, IC_BLE, IC_BGT};
  endfunction

endpackage

// File: rtl/pc_source_sequencer_branch_resolve.sv
// branch_resolve: combinational taken decision for conditional branches.
// Non-branch classes always resolve as not taken.
module branch_resolve
  import pc_seq_pkg::*;
(
  input  instr_class_e cls,
  input  logic         zero,
  input  logic         gt,
  output logic         taken
);

  always_comb begin
    taken = 1'b0;
    unique case (cls)
      IC_BEQ:  taken = zero;
      IC_BNE:  taken = ~zero;
      IC_BLE:  taken = ~gt;
      IC_BGT:  taken = gt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_source_sequencer.sv
// pc_source_sequencer: decides next-PC source per instruction and
// sequences exception vector loads. Stats: PCSEQ_BRANCH_STATS_EN.
module pc_source_sequencer
  import pc_seq_pkg::*;
#(
  parameter int         MEM_WAIT = 2,
  parameter logic [7:0] VEC_BASE = 8'd253
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] instr_class,
  input  logic       flags_valid,
  input  logic       zero,
  input  logic       gt,
  input  logic       exc_overflow,
  input  logic       exc_opcode,
  input  logic       exc_div0,
  output logic [2:0] pc_source,
  output logic       pc_write,
  output logic       epc_write,
  output logic [7:0] vec_addr,
  output logic       vec_read,
  output logic       done
`ifdef PCSEQ_BRANCH_STATS_EN
  ,
  output logic [15:0] branch_taken_cnt,
  output logic [15:0] branch_total_cnt
`endif
);

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_e       state_q, state_d;
  instr_class_e cls_q;
  logic [2:0]   pcs_q, pcs_d;
  logic [7:0]   vaddr_q, vaddr_d;
  logic [2:0]   wcnt_q, wcnt_d;
  logic [1:0]   cause;
  logic         exc_any;
  logic         taken;

  assign exc_any = exc_overflow | exc_opcode | exc_div0;

  always_comb begin
    cause = CAUSE_DIV0;
    if (exc_overflow)    cause = CAUSE_OVF;
    else if (exc_opcode) cause = CAUSE_OPC;
  end

  branch_resolve u_br (
    .cls   (cls_q),
    .zero  (zero),
    .gt    (gt),
    .taken (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cls_q   <= IC_SEQ;
      pcs_q   <= PCS_SEQ;
      vaddr_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcs_q   <= pcs_d;
      vaddr_q <= vaddr_d;
      wcnt_q  <= wcnt_d;
      if (state_q == S_IDLE && start)
        cls_q <= instr_class_e'(instr_class);
    end
  end

  always_comb begin
    state_d   = state_q;
    pcs_d     = pcs_q;
    vaddr_d   = vaddr_q;
    wcnt_d    = wcnt_q;
    pc_write  = 1'b0;
    epc_write = 1'b0;
    vec_read  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (exc_any) begin
          state_d = S_EXC_EPC;
          vaddr_d = VEC_BASE + {6'd0, cause};
        end else begin
          unique case (cls_q)
            IC_J, IC_JAL: begin
              pcs_d   = PCS_JUMP;
              state_d = S_COMMIT;
            end
            IC_JR: begin
              pcs_d   = PCS_REGA;
              state_d = S_COMMIT;
            end
            IC_BEQ, IC_BNE, IC_BLE, IC_BGT:
              state_d = S_WAIT_FLAGS;
            default: begin
              pcs_d   = PCS_SEQ;
              state_d = S_COMMIT;
            end
          endcase
        end
      end
      S_WAIT_FLAGS: begin
        if (exc_any) begin
          state_d = S_EXC_EPC;
          vaddr_d = VEC_BASE + {6'd0, cause};
        end else if (flags_valid) begin
          pcs_d   = taken ? PCS_BRANCH : PCS_SEQ;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // a late exception still wins: the PC load is withheld
        if (exc_any) begin
          state_d = S_EXC_EPC;
          vaddr_d = VEC_BASE + {6'd0, cause};
        end else begin
          pc_write = 1'b1;
          done     = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_EXC_EPC: begin
        epc_write = 1'b1;
        wcnt_d    = '0;
        state_d   = S_EXC_READ;
      end
      S_EXC_READ: begin
        vec_read = 1'b1;
        if (wcnt_q == WAIT_LAST) begin
          pcs_d   = PCS_EXCVEC;
          state_d = S_EXC_LOAD;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      S_EXC_LOAD: begin
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc_source = pcs_q;
  assign vec_addr  = vaddr_q;

`ifdef PCSEQ_BRANCH_STATS_EN
  logic br_commit;

  assign br_commit = (state_q == S_COMMIT) && !exc_any && is_branch(cls_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_taken_cnt <= '0;
      branch_total_cnt <= '0;
    end else if (br_commit) begin
      if (branch_total_cnt != 16'hFFFF)
        branch_total_cnt <= branch_total_cnt + 16'd1;
      if (pcs_q == PCS_BRANCH && branch_taken_cnt != 16'hFFFF)
        branch_taken_cnt <= branch_taken_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pc_source_sequencer.md
Name: pc_source_sequencer

Overview:
- Producer side of the PC-source select interface: the sequential controller that decides each instruction's next-PC source.
- Drives the 3-bit select consumed by the PC-source mux, plus PC and EPC write strobes.
- Sits inside the multicycle control path, between the main control FSM (per-instruction start, decoded class) and the datapath (ALU flags, exception causes).

Parameters:
- MEM_WAIT, 2, cycles to hold the exception-vector read before loading PC (range 1..7).
- VEC_BASE, 8'd253, byte address of the first exception vector (overflow=253, opcode=254, div0=255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  one-cycle pulse from main FSM: new instruction decoded.
- instr_class  in  3  decoded class (package enum: SEQ, BEQ, BNE, BLE, BGT, J, JR, JAL).
- flags_valid  in  1  ALU compare flags are valid this cycle.
- zero  in  1  ALU zero flag.
- gt  in  1  ALU greater-than flag.
- exc_overflow  in  1  overflow exception request.
- exc_opcode  in  1  invalid-opcode request.
- exc_div0  in  1  divide-by-zero request.
- pc_source  out  3  select to PC-source mux: 000 PC+4, 001 ALUOut branch target, 010 jump target, 011 register A, 100 exception vector (memory data, zero-extended).
- pc_write  out  1  one-cycle PC load strobe.
- epc_write  out  1  one-cycle EPC capture strobe.
- vec_addr  out  8  memory address of the exception vector being read.
- vec_read  out  1  memory read request for the vector.
- done  out  1  one-cycle pulse: PC update for this instruction complete.

Behaviour:
- Reset: state IDLE; pc_source=000; pc_write, epc_write, vec_read, done = 0; vec_addr=0. Reset mid-operation aborts with no PC write.
- States: IDLE, DECIDE, WAIT_FLAGS, COMMIT, EXC_EPC, EXC_READ, EXC_LOAD.
- IDLE: start=1 -> DECIDE. Outputs idle.
- DECIDE (1 cycle):
  - SEQ: pc_source=000 -> COMMIT.
  - J/JAL: pc_source=010 -> COMMIT.
  - JR: pc_source=011 -> COMMIT.
  - Branch classes -> WAIT_FLAGS.
- WAIT_FLAGS: hold until flags_valid=1.
  - Taken rules: BEQ zero=1; BNE zero=0; BLE gt=0; BGT gt=1.
  - Taken -> pc_source=001; not taken -> pc_source=000; then COMMIT.
- COMMIT: pc_write=1 for exactly one cycle with pc_source stable; done=1 same cycle -> IDLE.
- Exceptions:
  - Any exc_* sampled high in DECIDE, WAIT_FLAGS or COMMIT pre-empts the normal path. pc_write is suppressed if not yet issued -> EXC_EPC.
  - Priority: overflow > opcode > div0.
- EXC_EPC: epc_write=1 for one cycle.
  - vec_addr = VEC_BASE + cause index, where cause index is 0 (overflow), 1 (opcode) or 2 (div0).
  - -> EXC_READ.
- EXC_READ: vec_read=1 for MEM_WAIT cycles; vec_addr held -> EXC_LOAD.
- EXC_LOAD: pc_source=100, pc_write=1, done=1 for one cycle -> IDLE.
- Timing:
  - pc_source is registered and changes only on state entry; never changes in a cycle where pc_write=1.
  - Latency start -> done: 2 cycles (non-branch); 2 + flag-wait cycles (branch); 3 + MEM_WAIT cycles (exception from DECIDE).
- Boundaries:
  - start while not IDLE: ignored.
  - Simultaneous exc_* with flags_valid: exception wins.
  - exc_* in IDLE: ignored.
  - Undefined class encoding: treated as SEQ.

Optional Feature:
- Macro PCSEQ_BRANCH_STATS_EN.
- Defined:
  - Adds output branch_taken_cnt[15:0] and branch_total_cnt[15:0].
  - Each increments by 1 at COMMIT of a branch class (taken count only when taken).
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Package pc_seq_pkg holds:
  - instr_class enum.
  - pc_source encodings (PCS_SEQ=000, PCS_BRANCH=001, PCS_JUMP=010, PCS_REGA=011, PCS_EXCVEC=100).
  - FSM state enum.
  - Exception cause index constants.
- One sub-module, branch_resolve: combinational taken decision from instr_class, zero, gt. The FSM stays in the top.

Test Plan:
- Reset mid-operation: start with class SEQ, assert reset in COMMIT -> pc_write=0, pc_source=000, state IDLE, no done.
- SEQ and J: start with class SEQ -> pc_source=000 and pc_write pulse 2 cycles after start. Same for J with pc_source=010.
- BEQ taken: BEQ, flags_valid after 3 cycles with zero=1 -> pc_source=001, pc_write=1 one cycle, done. Repeat with zero=0 -> pc_source=000.
- BGT / BLE: BGT with gt=1 -> 001; BLE with gt=1 -> 000. BNE with zero=0 -> 001.
- Exception priority: overflow and div0 both raised in DECIDE:
  - epc_write pulse; vec_addr=253; vec_read high exactly MEM_WAIT=2 cycles.
  - Then pc_source=100 with pc_write; no branch-path pc_write issued.
- With PCSEQ_BRANCH_STATS_EN, 3 branches (2 taken) -> total=3, taken=2. Preload near 16'hFFFF -> saturates.
